// File: rtl/axi_write_sequencer_pkg.sv
// Shared AXI write-path definitions: state encoding, slave index type and
// the default-slave index used by the address decoder and the sequencer.
package axi_write_sequencer_pkg;

  localparam int AXI_LEN_BITS = 4;
  localparam int AXI_SEL_BITS = 2;
  localparam int DEF_SLAVE    = 2;

  typedef logic [AXI_SEL_BITS-1:0] slv_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    AW,
    W,
    B
  } wr_state_t;

endpackage

// File: rtl/axi_write_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at the requester just
// after the last grant, so the previous winner has the lowest priority.
module rr_arbiter #(
  parameter int NUM_M = 2,
  parameter int IDX_W = 1
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [NUM_M-1:0] gnt_oh,
  output logic [IDX_W-1:0] gnt_idx
);

  // Scan requesters in rotating order and take the first one asserted.
  always_comb begin
    int cand;
    logic found;
    cand    = 0;
    found   = 1'b0;
    gnt_oh  = '0;
    gnt_idx = '0;
    for (int i = 1; i <= NUM_M; i++) begin
      cand = (int'(last) + i) % NUM_M;
      if (!found && req[cand]) begin
        found        = 1'b1;
        gnt_oh[cand] = 1'b1;
        gnt_idx      = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/axi_write_sequencer.sv
// Write-path sequencer for the 2-master / 3-slave AXI interconnect. Grants one
// AW at a time, locks the master/slave pair through W and B, gates the
// valid/ready handshakes and counts W beats against AWLEN.
module axi_write_sequencer
  import axi_write_sequencer_pkg::*;
#(
  parameter int NUM_M     = 2,
  parameter int NUM_S     = 3,
  parameter int SEL_BITS  = AXI_SEL_BITS,
  parameter int LEN_BITS  = AXI_LEN_BITS,
  parameter int DEF_SLAVE = axi_write_sequencer_pkg::DEF_SLAVE,
  localparam int M_IDX_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic [NUM_M-1:0]             AWVALID_M,
  input  logic [NUM_M*SEL_BITS-1:0]    AWSEL_M,
  input  logic [NUM_M*LEN_BITS-1:0]    AWLEN_M,
  input  logic [NUM_S-1:0]             AWREADY_S,
  input  logic [NUM_M-1:0]             WVALID_M,
  input  logic [NUM_M-1:0]             WLAST_M,
  input  logic [NUM_S-1:0]             WREADY_S,
  input  logic [NUM_S-1:0]             BVALID_S,
  input  logic [NUM_M-1:0]             BREADY_M,
  output logic [NUM_S-1:0]             AWVALID_S,
  output logic [NUM_M-1:0]             AWREADY_M,
  output logic [NUM_S-1:0]             WVALID_S,
  output logic [NUM_M-1:0]             WREADY_M,
  output logic [NUM_M-1:0]             BVALID_M,
  output logic [NUM_S-1:0]             BREADY_S,
  output logic [M_IDX_W-1:0]           MSEL,
  output logic [SEL_BITS-1:0]          SSEL,
  output logic                         BUSY,
  output logic                         LEN_ERR
);

  if (SEL_BITS < $clog2(NUM_S) || DEF_SLAVE >= NUM_S) begin : g_bad_cfg
    $error("axi_write_sequencer: SEL_BITS too narrow or DEF_SLAVE out of range");
  end

  wr_state_t             state;
  logic [M_IDX_W-1:0]    msel_q;
  logic [M_IDX_W-1:0]    rr_last;
  logic [SEL_BITS-1:0]   ssel_q;
  logic [LEN_BITS-1:0]   beat_cnt;
  logic [LEN_BITS-1:0]   len_q;
  logic                  len_err_q;

  logic [NUM_M-1:0]      gnt_oh;
  logic [M_IDX_W-1:0]    gnt_idx;
  logic                  arb_any;
  logic [SEL_BITS-1:0]   win_sel;
  logic [LEN_BITS-1:0]   win_len;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  b_hs;
  logic                  w_last;

  rr_arbiter #(
    .NUM_M (NUM_M),
    .IDX_W (M_IDX_W)
  ) u_arb (
    .req     (AWVALID_M),
    .last    (rr_last),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx)
  );

  assign arb_any = |gnt_oh;
  assign win_sel = AWSEL_M[gnt_idx*SEL_BITS +: SEL_BITS];
  assign win_len = AWLEN_M[gnt_idx*LEN_BITS +: LEN_BITS];

  assign aw_hs  = (state == AW) && AWVALID_M[msel_q] && AWREADY_S[ssel_q];
  assign w_hs   = (state == W)  && WVALID_M[msel_q]  && WREADY_S[ssel_q];
  assign b_hs   = (state == B)  && BVALID_S[ssel_q]  && BREADY_M[msel_q];
  assign w_last = WLAST_M[msel_q];

  assign MSEL    = msel_q;
  assign SSEL    = ssel_q;
  assign BUSY    = (state != IDLE);
  assign LEN_ERR = len_err_q;

  // Route only the locked pair's handshake for the channel of the current phase.
  always_comb begin
    AWVALID_S = '0;
    AWREADY_M = '0;
    WVALID_S  = '0;
    WREADY_M  = '0;
    BVALID_M  = '0;
    BREADY_S  = '0;
    case (state)
      AW: begin
        AWVALID_S[ssel_q] = AWVALID_M[msel_q];
        AWREADY_M[msel_q] = AWREADY_S[ssel_q];
      end
      W: begin
        WVALID_S[ssel_q]  = WVALID_M[msel_q];
        WREADY_M[msel_q]  = WREADY_S[ssel_q];
      end
      B: begin
        BVALID_M[msel_q]  = BVALID_S[ssel_q];
        BREADY_S[ssel_q]  = BREADY_M[msel_q];
      end
      default: ;
    endcase
  end

  // Transaction FSM: grant in IDLE, then walk AW -> W -> B for the locked pair.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      msel_q    <= '0;
      ssel_q    <= '0;
      rr_last   <= M_IDX_W'(NUM_M - 1);
      beat_cnt  <= '0;
      len_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            msel_q   <= gnt_idx;
            ssel_q   <= win_sel;
            len_q    <= win_len;
            beat_cnt <= '0;
            state    <= AW;
          end
        end
        AW: begin
          if (aw_hs) begin
            rr_last <= msel_q;
            state   <= W;
          end
        end
        W: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (w_last) begin
              state <= B;
              if (beat_cnt != len_q) len_err_q <= 1'b1;
            end else if (beat_cnt == len_q) begin
              len_err_q <= 1'b1;
            end
          end
        end
        B: begin
          if (b_hs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_write_sequencer.sv
// Directed bench for axi_write_sequencer: inputs change on the falling edge,
// outputs are compared 1 ns later, state advances on the rising edge.
module tb_axi_write_sequencer;

  logic       ACLK = 1'b0;
  logic       ARESETn;
  logic [1:0] AWVALID_M;
  logic [3:0] AWSEL_M;
  logic [7:0] AWLEN_M;
  logic [2:0] AWREADY_S;
  logic [1:0] WVALID_M;
  logic [1:0] WLAST_M;
  logic [2:0] WREADY_S;
  logic [2:0] BVALID_S;
  logic [1:0] BREADY_M;
  logic [2:0] AWVALID_S;
  logic [1:0] AWREADY_M;
  logic [2:0] WVALID_S;
  logic [1:0] WREADY_M;
  logic [1:0] BVALID_M;
  logic [2:0] BREADY_S;
  logic       MSEL;
  logic [1:0] SSEL;
  logic       BUSY;
  logic       LEN_ERR;

  int n_checks = 0;
  int n_errors = 0;

  always #5 ACLK = ~ACLK;

  axi_write_sequencer dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .AWVALID_M (AWVALID_M),
    .AWSEL_M   (AWSEL_M),
    .AWLEN_M   (AWLEN_M),
    .AWREADY_S (AWREADY_S),
    .WVALID_M  (WVALID_M),
    .WLAST_M   (WLAST_M),
    .WREADY_S  (WREADY_S),
    .BVALID_S  (BVALID_S),
    .BREADY_M  (BREADY_M),
    .AWVALID_S (AWVALID_S),
    .AWREADY_M (AWREADY_M),
    .WVALID_S  (WVALID_S),
    .WREADY_M  (WREADY_M),
    .BVALID_M  (BVALID_M),
    .BREADY_S  (BREADY_S),
    .MSEL      (MSEL),
    .SSEL      (SSEL),
    .BUSY      (BUSY),
    .LEN_ERR   (LEN_ERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    AWVALID_M = '0; AWREADY_S = '0;
    WVALID_M  = '0; WLAST_M   = '0; WREADY_S = '0;
    BVALID_S  = '0; BREADY_M  = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".awvalid_s"}, AWVALID_S, 0);
    chk({tag, ".awready_m"}, AWREADY_M, 0);
    chk({tag, ".wvalid_s"},  WVALID_S,  0);
    chk({tag, ".wready_m"},  WREADY_M,  0);
    chk({tag, ".bvalid_m"},  BVALID_M,  0);
    chk({tag, ".bready_s"},  BREADY_S,  0);
    chk({tag, ".busy"},      BUSY,      0);
    chk({tag, ".len_err"},   LEN_ERR,   0);
    chk({tag, ".msel"},      MSEL,      0);
    chk({tag, ".ssel"},      SSEL,      0);
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESETn = 1'b0;
    clear_inputs();
    @(negedge ACLK);
    ARESETn = 1'b1;
  endtask

  // One IDLE cycle with the request, one AW cycle with the handshake.
  // Returns at the falling edge where the DUT sits in W.
  task automatic aw_phase(input string tag, input logic [1:0] req, input int m, input int s);
    @(negedge ACLK);
    AWVALID_M = req;
    AWREADY_S = '1;
    #1;
    chk({tag, ".idle_busy"}, BUSY, 0);
    chk({tag, ".idle_awvalid_s"}, AWVALID_S, 0);
    @(negedge ACLK);
    #1;
    chk({tag, ".aw_busy"}, BUSY, 1);
    chk({tag, ".aw_msel"}, MSEL, m);
    chk({tag, ".aw_ssel"}, SSEL, s);
    chk({tag, ".aw_awvalid_s"}, AWVALID_S, 1 << s);
    chk({tag, ".aw_awready_m"}, AWREADY_M, 1 << m);
    @(negedge ACLK);
    AWVALID_M = req & ~(2'b01 << m);
  endtask

  // W beats 0..last_at (WLAST on last_at), then the B handshake, then IDLE.
  task automatic wb_phase(input string tag, input int m, input int s, input int last_at,
                          input logic exp_err);
    WVALID_M = 2'b01 << m;
    WREADY_S = '1;
    for (int b = 0; b <= last_at; b++) begin
      WLAST_M = (b == last_at) ? (2'b01 << m) : 2'b00;
      #1;
      chk({tag, ".w_wvalid_s"}, WVALID_S, 1 << s);
      chk({tag, ".w_wready_m"}, WREADY_M, 1 << m);
      if (b > 0) chk({tag, ".w_len_err"}, LEN_ERR, 0);
      @(negedge ACLK);
    end
    WVALID_M = '0;
    WLAST_M  = '0;
    BVALID_S = '1;
    BREADY_M = '1;
    #1;
    chk({tag, ".b_len_err"}, LEN_ERR, exp_err);
    chk({tag, ".b_wready_m"}, WREADY_M, 0);
    chk({tag, ".b_bvalid_m"}, BVALID_M, 1 << m);
    chk({tag, ".b_bready_s"}, BREADY_S, 1 << s);
    @(negedge ACLK);
    BVALID_S  = '0;
    BREADY_M  = '0;
    AWVALID_M = '0;
    #1;
    chk({tag, ".end_busy"}, BUSY, 0);
    chk({tag, ".end_len_err"}, LEN_ERR, 0);
    chk({tag, ".end_msel_hold"}, MSEL, m);
    chk({tag, ".end_ssel_hold"}, SSEL, s);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETn = 1'b0;
    AWSEL_M = '0;
    AWLEN_M = '0;
    clear_inputs();
    @(negedge ACLK);
    #1;
    chk_all_zero("reset");
    @(negedge ACLK);
    ARESETn = 1'b1;

    // Single burst M1 -> S1, AWLEN=3; S0 also asserts BVALID but must not leak.
    AWSEL_M = {2'd1, 2'd0};
    AWLEN_M = {4'd3, 4'd0};
    aw_phase("single", 2'b10, 1, 1);
    wb_phase("single", 1, 1, 3, 1'b0);

    // Concurrent requests after reset: M0, then M1, then M0 again.
    do_reset();
    AWSEL_M = {2'd1, 2'd0};
    AWLEN_M = {4'd0, 4'd0};
    aw_phase("rr0", 2'b11, 0, 0);
    wb_phase("rr0", 0, 0, 0, 1'b0);
    aw_phase("rr1", 2'b11, 1, 1);
    wb_phase("rr1", 1, 1, 0, 1'b0);
    aw_phase("rr2", 2'b11, 0, 0);
    wb_phase("rr2", 0, 0, 0, 1'b0);

    // W before AW: AWREADY held low for 5 cycles while M1 offers W data.
    @(negedge ACLK);
    AWSEL_M   = {2'd0, 2'd0};
    AWLEN_M   = {4'd1, 4'd0};
    AWVALID_M = 2'b10;
    AWREADY_S = '0;
    WVALID_M  = 2'b10;
    WREADY_S  = '1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("wbefore.wready_m", WREADY_M, 0);
      chk("wbefore.wvalid_s", WVALID_S, 0);
      @(negedge ACLK);
    end
    AWREADY_S = 3'b001;
    #1;
    chk("wbefore.awready_m", AWREADY_M, 2'b10);
    chk("wbefore.wready_m_aw", WREADY_M, 0);
    @(negedge ACLK);
    AWVALID_M = '0;
    wb_phase("wbefore", 1, 0, 1, 1'b0);

    // Early WLAST: AWLEN=3 but WLAST on the 2nd beat.
    AWSEL_M = {2'd0, 2'd1};
    AWLEN_M = {4'd0, 4'd3};
    aw_phase("early", 2'b01, 0, 1);
    wb_phase("early", 0, 1, 1, 1'b1);

    // Default slave: M1 decodes to SD (index 2).
    AWSEL_M = {2'd2, 2'd0};
    AWLEN_M = {4'd0, 4'd0};
    aw_phase("defslv", 2'b10, 1, 2);
    wb_phase("defslv", 1, 2, 0, 1'b0);

    // Reset during the 2nd of 4 W beats, then a fresh burst.
    AWSEL_M = {2'd0, 2'd0};
    AWLEN_M = {4'd0, 4'd3};
    aw_phase("midrst", 2'b01, 0, 0);
    WVALID_M = 2'b01;
    WREADY_S = '1;
    WLAST_M  = '0;
    @(negedge ACLK);
    ARESETn = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge ACLK);
    ARESETn = 1'b1;
    clear_inputs();
    AWSEL_M = {2'd0, 2'd1};
    AWLEN_M = {4'd0, 4'd0};
    aw_phase("postrst", 2'b11, 0, 1);
    wb_phase("postrst", 0, 1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
